// File: rtl/lsu_mem_req.sv
// LSU memory request engine: accepts one load/store at a time from EXU, presents a
// word-aligned request with byte strobes and lane-shifted write data to the data
// memory, waits for the read data (bounded by a timeout) and returns an extended
// load result, a store acknowledge or an error response to WBU.
module lsu_mem_req #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Last counter value before the timeout fires; only meaningful when TIMEOUT != 0.
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         off_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               wen_q;

    // Size 3 is illegal; halves must be 2-byte aligned, words 4-byte aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return (off != 2'd0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 8'h01 << off;
            2'd1:    return 8'h03 << off;
            default: return 8'h0F;
        endcase
    endfunction

    // Pull the addressed lanes down to bit 0, then sign- or zero-extend by size.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0]        s;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        s = word >> {off, 3'b000};
        b = s[7:0];
        h = s[15:0];
        case (size)
            2'd0:    r = uns ? signed'({24'h0, s[7:0]})  : 32'(b);
            2'd1:    r = uns ? signed'({16'h0, s[15:0]}) : 32'(h);
            default: r = signed'(s);
        endcase
        return r;
    endfunction

    // Request FSM with all handshake and memory-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            wen_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_raddr  <= 32'h0;
            mem_waddr  <= 32'h0;
            mem_wmask  <= 8'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        wen_q     <= req_wen;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            // Rejected without touching memory.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                            mem_wen   <= req_wen;
                            mem_raddr <= {req_addr[31:2], 2'b00};
                            mem_waddr <= {req_addr[31:2], 2'b00};
                            mem_wmask <= lane_mask(req_size, req_addr[1:0]);
                            mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wen   <= 1'b0;
                        mem_wmask <= 8'h0;
                        if (wen_q) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'h0;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    // Read data arriving on the timeout cycle still counts as success.
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_extend(mem_rdata, off_q, size_q, uns_q);
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// Testbench for lsu_mem_req: table vectors, hand-written multi-cycle sequences and
// randomized transactions against a byte-level reference model.
module tb_lsu_mem_req;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int errors = 0;
    int checks = 0;

    lsu_mem_req #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic [7:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        hung;
        logic        saw_mem;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [7:0]  wmask;
        logic [31:0] wdata;
        logic        wen;
        logic        mstable;
        logic [31:0] mcyc;
        logic [31:0] wcyc;
        logic        err;
        logic [31:0] rdata;
        logic        rstable;
        logic        idle_after;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                                input logic exp_mem, input logic [31:0] exp_addr,
                                input logic [7:0] exp_wmask, input logic [31:0] exp_wdata,
                                input logic exp_err, input logic [31:0] exp_rdata);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.rdata = rdata; v.exp_mem = exp_mem; v.exp_addr = exp_addr;
        v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Reference model: works byte by byte on the memory word.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          nb;
        int          off;
        logic [31:0] val;
        r   = v;
        off = int'(v.addr[1:0]);
        nb  = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        r.exp_err   = (v.size == 2'd3) || ((off % nb) != 0);
        r.exp_mem   = !r.exp_err;
        r.exp_addr  = v.addr - 32'(off);
        r.exp_wmask = 8'h0;
        r.exp_wdata = v.wdata << (8 * off);
        val = 32'h0;
        if (!r.exp_err) begin
            for (int i = 0; i < nb; i++) r.exp_wmask[off + i] = 1'b1;
            if (!v.wen) begin
                for (int i = 0; i < nb; i++) val[8*i +: 8] = v.rdata[8*(off + i) +: 8];
                if (!v.uns && nb < 4 && val[8*nb - 1])
                    for (int j = nb; j < 4; j++) val[8*j +: 8] = 8'hFF;
            end
        end
        r.exp_rdata = val;
        return r;
    endfunction

    // One full transaction with programmable memory/response back-pressure.
    // rv_dly < 0 means the memory never returns read data.
    task automatic txn(input vec_t v, input int mrdy_dly, input int rv_dly, input int rrdy_dly,
                       output obs_t o);
        int   n, mcyc, wcyc;
        logic hs;
        o = '0;
        o.mstable = 1'b1;
        o.rstable = 1'b1;
        n = 0; mcyc = 0; wcyc = 0; hs = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_unsigned = v.uns;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && n < 100) begin
            if (mem_valid) begin
                if (!o.saw_mem) begin
                    o.raddr = mem_raddr; o.waddr = mem_waddr; o.wmask = mem_wmask;
                    o.wdata = mem_wdata; o.wen = mem_wen;
                end else if (mem_raddr !== o.raddr || mem_waddr !== o.waddr ||
                             mem_wmask !== o.wmask || mem_wdata !== o.wdata || mem_wen !== o.wen) begin
                    o.mstable = 1'b0;
                end
                o.saw_mem = 1'b1;
                mem_ready = (mcyc >= mrdy_dly);
                mcyc++;
                if (mem_ready) hs = 1'b1;
            end else begin
                mem_ready = 1'b0;
                if (hs) begin
                    mem_rvalid = (rv_dly >= 0 && wcyc >= rv_dly);
                    mem_rdata  = mem_rvalid ? v.rdata : $urandom;
                    wcyc++;
                end
            end
            @(negedge clk);
            n++;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        o.hung = !resp_valid;
        o.mcyc = mcyc;
        o.wcyc = wcyc;
        o.err = resp_err;
        o.rdata = resp_rdata;
        for (int k = 0; k < rrdy_dly; k++) begin
            @(negedge clk);
            if (!resp_valid || resp_err !== o.err || resp_rdata !== o.rdata) o.rstable = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        o.idle_after = !resp_valid && req_ready;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input obs_t o, input int mrdy_dly);
        chk($sformatf("%s.hang", tag), 32'(o.hung), 32'd0);
        chk($sformatf("%s.mem_access", tag), 32'(o.saw_mem), 32'(v.exp_mem));
        if (v.exp_mem) begin
            chk($sformatf("%s.raddr", tag), o.raddr, v.exp_addr);
            chk($sformatf("%s.waddr", tag), o.waddr, v.exp_addr);
            chk($sformatf("%s.wmask", tag), 32'(o.wmask), 32'(v.exp_wmask));
            chk($sformatf("%s.wdata", tag), o.wdata, v.exp_wdata);
            chk($sformatf("%s.mem_wen", tag), 32'(o.wen), 32'(v.wen));
            chk($sformatf("%s.mem_stable", tag), 32'(o.mstable), 32'd1);
            chk($sformatf("%s.mem_cycles", tag), o.mcyc, 32'(mrdy_dly + 1));
        end
        chk($sformatf("%s.err", tag), 32'(o.err), 32'(v.exp_err));
        chk($sformatf("%s.rdata", tag), o.rdata, v.exp_rdata);
        chk($sformatf("%s.resp_stable", tag), 32'(o.rstable), 32'd1);
        chk($sformatf("%s.idle_after", tag), 32'(o.idle_after), 32'd1);
    endtask

    vec_t tbl[11];
    vec_t v;
    obs_t o;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        //            wen addr          wdata         sz uns rdata        mem addr          mask   wdata         err rdata
        tbl[0]  = mk(0, 32'h80000003, 32'h00000000, 0, 0, 32'h80FF1234, 1, 32'h80000000, 8'h08, 32'h00000000, 0, 32'hFFFFFF80);
        tbl[1]  = mk(0, 32'h80000003, 32'h00000000, 0, 1, 32'h80FF1234, 1, 32'h80000000, 8'h08, 32'h00000000, 0, 32'h00000080);
        tbl[2]  = mk(1, 32'h80000002, 32'h0000ABCD, 1, 0, 32'h00000000, 1, 32'h80000000, 8'h0C, 32'hABCD0000, 0, 32'h00000000);
        tbl[3]  = mk(0, 32'h80000006, 32'h00000000, 2, 0, 32'h12345678, 0, 32'h00000000, 8'h00, 32'h00000000, 1, 32'h00000000);
        tbl[4]  = mk(0, 32'h10000002, 32'h00000000, 1, 0, 32'h80017FFF, 1, 32'h10000000, 8'h0C, 32'h00000000, 0, 32'hFFFF8001);
        tbl[5]  = mk(0, 32'h10000000, 32'h00000000, 1, 1, 32'h1234F00D, 1, 32'h10000000, 8'h03, 32'h00000000, 0, 32'h0000F00D);
        tbl[6]  = mk(1, 32'h20000004, 32'hDEADBEEF, 2, 0, 32'h00000000, 1, 32'h20000004, 8'h0F, 32'hDEADBEEF, 0, 32'h00000000);
        tbl[7]  = mk(1, 32'h20000001, 32'h000000A5, 0, 0, 32'h00000000, 1, 32'h20000000, 8'h02, 32'h0000A500, 0, 32'h00000000);
        tbl[8]  = mk(0, 32'h00000000, 32'h00000000, 3, 0, 32'h00000000, 0, 32'h00000000, 8'h00, 32'h00000000, 1, 32'h00000000);
        tbl[9]  = mk(1, 32'h00000001, 32'h00000000, 1, 0, 32'h00000000, 0, 32'h00000000, 8'h00, 32'h00000000, 1, 32'h00000000);
        tbl[10] = mk(0, 32'h30000008, 32'h00000000, 2, 0, 32'hCAFEBABE, 1, 32'h30000008, 8'h0F, 32'h00000000, 0, 32'hCAFEBABE);

        // Reset values, sampled while reset is held.
        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.mem_valid", 32'(mem_valid), 32'd0);
        chk("rst.mem_wen", 32'(mem_wen), 32'd0);
        chk("rst.mem_raddr", mem_raddr, 32'h0);
        chk("rst.mem_waddr", mem_waddr, 32'h0);
        chk("rst.mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Table vectors with no back-pressure.
        for (int i = 0; i < 11; i++) begin
            txn(tbl[i], 0, 0, 0, o);
            check_vec($sformatf("tbl%0d", i), tbl[i], o, 0);
        end

        // Minimum latency: memory ready and read-valid held high throughout.
        @(negedge clk);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h00000040; req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat.t1_mem_valid", 32'(mem_valid), 32'd1);
        chk("lat.t1_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("lat.t2_mem_valid", 32'(mem_valid), 32'd0);
        chk("lat.t2_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("lat.t3_resp_valid", 32'(resp_valid), 32'd1);
        chk("lat.t3_rdata", resp_rdata, 32'h11223344);
        mem_ready = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("lat.req_ready", 32'(req_ready), 32'd1);

        // Back-pressure on both handshakes.
        txn(tbl[4], 5, 2, 3, o);
        check_vec("bp_load", tbl[4], o, 5);
        txn(tbl[2], 5, 0, 3, o);
        check_vec("bp_store", tbl[2], o, 5);

        // Timeout: no read data ever.
        v = tbl[10];
        v.exp_err = 1'b1;
        v.exp_rdata = 32'h0;
        txn(v, 0, -1, 0, o);
        check_vec("timeout", v, o, 0);
        chk("timeout.wait_cycles", o.wcyc, 32'd8);

        // Read data on the final WAIT cycle beats the timeout.
        txn(tbl[10], 0, 7, 0, o);
        check_vec("rv_last", tbl[10], o, 0);
        chk("rv_last.wait_cycles", o.wcyc, 32'd8);

        // Reset asserted while waiting for read data.
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h00000050; req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rstwait.in_wait", 32'({mem_valid, resp_valid, req_ready}), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstwait.req_ready", 32'(req_ready), 32'd1);
        chk("rstwait.resp_valid", 32'(resp_valid), 32'd0);
        chk("rstwait.mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h55AA55AA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstwait.late_rvalid%0d", k), 32'({resp_valid, req_ready}), 32'd1);
        end
        mem_rvalid = 1'b0;
        txn(tbl[0], 0, 0, 0, o);
        check_vec("after_rst", tbl[0], o, 0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 150; i++) begin
            v = '0;
            v.wen   = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.size  = 2'($urandom_range(0, 3));
            v.uns   = 1'($urandom_range(0, 1));
            v.rdata = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (v.size == 2'd1) v.addr[0] = 1'b0;
                if (v.size == 2'd2) v.addr[1:0] = 2'b00;
            end
            v = model(v);
            begin
                int md, rd, pd;
                md = $urandom_range(0, 3);
                rd = $urandom_range(0, 3);
                pd = $urandom_range(0, 2);
                txn(v, md, rd, pd, o);
                check_vec($sformatf("rnd%0d", i), v, o, md);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
